// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Purpose  : Scan-chain sequencer. Shifts a pattern in, pulses a capture
//            window, and unloads the previous capture while loading the next.
// Revision : 1.0
// ============================================================================
module scan_chain_ctrl #(
    parameter int CHAIN_LEN      = 16,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 LOAD_VALID,
    input  logic [CHAIN_LEN-1:0] LOAD_DATA,
    output logic                 LOAD_READY,
    input  logic                 FLUSH,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 CAP_STROBE,
    output logic                 RESP_VALID,
    output logic [CHAIN_LEN-1:0] RESP_DATA,
    input  logic                 RESP_READY,
    output logic                 BUSY
);

    localparam int CNT_MAX = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'(CAPTURE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_PAT   = 1'b0,
        MODE_FLUSH = 1'b1
    } mode_t;

    state_t               state_q,      state_d;
    mode_t                mode_q,       mode_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [CHAIN_LEN-1:0] shreg_q,      shreg_d;
    logic [CHAIN_LEN-2:0] resp_sr_q,    resp_sr_d;
    logic [CHAIN_LEN-1:0] resp_data_q,  resp_data_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 have_cap_q,   have_cap_d;
    logic                 se_q,         se_d;
    logic                 si_q,         si_d;
    logic                 cap_q,        cap_d;

    logic [CHAIN_LEN-1:0] w_resp_next;
    logic                 w_load_hs;
    logic                 w_flush_go;

    assign LOAD_READY = (state_q == ST_IDLE) && !resp_valid_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign SE         = se_q;
    assign SI         = si_q;
    assign CAP_STROBE = cap_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_DATA  = resp_data_q;

    assign w_load_hs   = LOAD_VALID && LOAD_READY;
    assign w_flush_go  = FLUSH && have_cap_q && !resp_valid_q;
    // SO is sampled before the edge that shifts the chain, so the first
    // sample is flop CHAIN_LEN-1 and ends up in the response MSB.
    assign w_resp_next = {resp_sr_q, SO};

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        resp_sr_d    = resp_sr_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        have_cap_d   = have_cap_q;
        se_d         = se_q;
        si_d         = si_q;
        cap_d        = cap_q;

        if (resp_valid_q && RESP_READY) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_load_hs) begin
                    // SI is registered, so the MSB goes out now and the
                    // remaining bits queue up behind it in shreg.
                    shreg_d = {LOAD_DATA[CHAIN_LEN-2:0], 1'b0};
                    si_d    = LOAD_DATA[CHAIN_LEN-1];
                    se_d    = 1'b1;
                    mode_d  = MODE_PAT;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else if (w_flush_go) begin
                    shreg_d = '0;
                    si_d    = 1'b0;
                    se_d    = 1'b1;
                    mode_d  = MODE_FLUSH;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                resp_sr_d = w_resp_next[CHAIN_LEN-2:0];
                if (cnt_q == LAST_SHIFT) begin
                    se_d  = 1'b0;
                    si_d  = 1'b0;
                    cnt_d = '0;
                    if (have_cap_q) begin
                        resp_data_d  = w_resp_next;
                        resp_valid_d = 1'b1;
                    end
                    if (mode_q == MODE_PAT) begin
                        cap_d   = 1'b1;
                        state_d = ST_CAPTURE;
                    end else begin
                        have_cap_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    si_d    = shreg_q[CHAIN_LEN-1];
                    shreg_d = {shreg_q[CHAIN_LEN-2:0], 1'b0};
                end
            end

            ST_CAPTURE: begin
                if (cnt_q == LAST_CAP) begin
                    cap_d      = 1'b0;
                    have_cap_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_PAT;
            cnt_q        <= '0;
            shreg_q      <= '0;
            resp_sr_q    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            have_cap_q   <= 1'b0;
            se_q         <= 1'b0;
            si_q         <= 1'b0;
            cap_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            resp_sr_q    <= resp_sr_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            have_cap_q   <= have_cap_d;
            se_q         <= se_d;
            si_q         <= si_d;
            cap_q        <= cap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_ctrl
// Purpose  : Directed self-checking bench for scan_chain_ctrl driving an
//            8-flop behavioural chain whose functional D input is ~Q.
// Revision : 1.0
// ============================================================================
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic         CLK        = 1'b0;
    logic         RST        = 1'b1;
    logic         LOAD_VALID = 1'b0;
    logic [N-1:0] LOAD_DATA  = '0;
    logic         FLUSH      = 1'b0;
    logic         RESP_READY = 1'b0;
    logic         SO;
    logic         LOAD_READY, SE, SI, CAP_STROBE, RESP_VALID, BUSY;
    logic [N-1:0] RESP_DATA;

    logic [N-1:0] chain = '0;
    int           n_pass  = 0;
    int           n_total = 0;

    scan_chain_ctrl #(
        .CHAIN_LEN      (N),
        .CAPTURE_CYCLES (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_READY (LOAD_READY),
        .FLUSH      (FLUSH),
        .SE         (SE),
        .SI         (SI),
        .SO         (SO),
        .CAP_STROBE (CAP_STROBE),
        .RESP_VALID (RESP_VALID),
        .RESP_DATA  (RESP_DATA),
        .RESP_READY (RESP_READY),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // Harness gates the chain clock: it moves only while shifting or capturing.
    always @(posedge CLK) begin
        if (SE)              chain <= {chain[N-2:0], SI};
        else if (CAP_STROBE) chain <= ~chain;
    end
    assign SO = chain[N-1];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        LOAD_VALID = 1'b1; LOAD_DATA = 8'h81;
        tick();
        LOAD_VALID = 1'b0;
        tick(2);
        n_total++; if (BUSY !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", BUSY); else n_pass++;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        n_total++; if (SE !== 1'b0) $display("FAIL rst_se: got %b want 0", SE); else n_pass++;
        n_total++; if (SI !== 1'b0) $display("FAIL rst_si: got %b want 0", SI); else n_pass++;
        n_total++; if (CAP_STROBE !== 1'b0) $display("FAIL rst_cap: got %b want 0", CAP_STROBE); else n_pass++;
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL rst_rv: got %b want 0", RESP_VALID); else n_pass++;
        n_total++; if (LOAD_READY !== 1'b1) $display("FAIL rst_lr: got %b want 1", LOAD_READY); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL rst_busy: got %b want 0", BUSY); else n_pass++;
    endtask

    task automatic test_first_load();
        logic [N-1:0] pat;
        pat = 8'hA5;
        LOAD_VALID = 1'b1; LOAD_DATA = pat;
        tick();
        LOAD_VALID = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_total++; if (SE !== 1'b1) $display("FAIL first_se[%0d]: got %b want 1", k, SE); else n_pass++;
            n_total++; if (SI !== pat[N-1-k]) $display("FAIL first_si[%0d]: got %b want %b", k, SI, pat[N-1-k]); else n_pass++;
            tick();
        end
        n_total++; if (SE !== 1'b0) $display("FAIL first_se_end: got %b want 0", SE); else n_pass++;
        n_total++; if (CAP_STROBE !== 1'b1) $display("FAIL first_cap: got %b want 1", CAP_STROBE); else n_pass++;
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL first_rv: got %b want 0", RESP_VALID); else n_pass++;
        tick();
        n_total++; if (CAP_STROBE !== 1'b0) $display("FAIL first_cap_end: got %b want 0", CAP_STROBE); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL first_busy: got %b want 0", BUSY); else n_pass++;
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL first_rv_idle: got %b want 0", RESP_VALID); else n_pass++;
        n_total++; if (chain !== 8'h5A) $display("FAIL first_chain: got %h want 5a", chain); else n_pass++;
    endtask

    task automatic test_second_load_backpressure();
        logic [N-1:0] pat;
        pat = 8'h3C;
        LOAD_VALID = 1'b1; LOAD_DATA = pat;
        tick();
        LOAD_VALID = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_total++; if (SI !== pat[N-1-k]) $display("FAIL second_si[%0d]: got %b want %b", k, SI, pat[N-1-k]); else n_pass++;
            n_total++; if (RESP_VALID !== 1'b0) $display("FAIL second_rv_early[%0d]: got %b want 0", k, RESP_VALID); else n_pass++;
            tick();
        end
        n_total++; if (RESP_VALID !== 1'b1) $display("FAIL second_rv: got %b want 1", RESP_VALID); else n_pass++;
        n_total++; if (RESP_DATA !== 8'h5A) $display("FAIL second_rd: got %h want 5a", RESP_DATA); else n_pass++;
        tick();
        n_total++; if (chain !== 8'hC3) $display("FAIL second_chain: got %h want c3", chain); else n_pass++;
        LOAD_VALID = 1'b1; LOAD_DATA = 8'h00;
        for (int k = 0; k < 5; k++) begin
            n_total++; if (LOAD_READY !== 1'b0) $display("FAIL bp_lr[%0d]: got %b want 0", k, LOAD_READY); else n_pass++;
            n_total++; if (RESP_DATA !== 8'h5A) $display("FAIL bp_rd[%0d]: got %h want 5a", k, RESP_DATA); else n_pass++;
            n_total++; if (BUSY !== 1'b0) $display("FAIL bp_busy[%0d]: got %b want 0", k, BUSY); else n_pass++;
            tick();
        end
        RESP_READY = 1'b1;
        tick();
        RESP_READY = 1'b0;
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL bp_rv_clear: got %b want 0", RESP_VALID); else n_pass++;
        n_total++; if (LOAD_READY !== 1'b1) $display("FAIL bp_lr_up: got %b want 1", LOAD_READY); else n_pass++;
        tick();
        LOAD_VALID = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_total++; if (SE !== 1'b1 || SI !== 1'b0) $display("FAIL bp_shift[%0d]: got se=%b si=%b want se=1 si=0", k, SE, SI); else n_pass++;
            tick();
        end
        n_total++; if (RESP_VALID !== 1'b1) $display("FAIL bp2_rv: got %b want 1", RESP_VALID); else n_pass++;
        n_total++; if (RESP_DATA !== 8'hC3) $display("FAIL bp2_rd: got %h want c3", RESP_DATA); else n_pass++;
        RESP_READY = 1'b1;
        tick();
        RESP_READY = 1'b0;
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL bp2_rv_clear: got %b want 0", RESP_VALID); else n_pass++;
        n_total++; if (chain !== 8'hFF) $display("FAIL bp2_chain: got %h want ff", chain); else n_pass++;
    endtask

    task automatic test_flush();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_total++; if (SE !== 1'b1 || SI !== 1'b0 || CAP_STROBE !== 1'b0)
                $display("FAIL flush_shift[%0d]: got se=%b si=%b cap=%b want 1 0 0", k, SE, SI, CAP_STROBE); else n_pass++;
            tick();
        end
        n_total++; if (SE !== 1'b0 || CAP_STROBE !== 1'b0) $display("FAIL flush_end: got se=%b cap=%b want 0 0", SE, CAP_STROBE); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL flush_busy: got %b want 0", BUSY); else n_pass++;
        n_total++; if (RESP_VALID !== 1'b1) $display("FAIL flush_rv: got %b want 1", RESP_VALID); else n_pass++;
        n_total++; if (RESP_DATA !== 8'hFF) $display("FAIL flush_rd: got %h want ff", RESP_DATA); else n_pass++;
        RESP_READY = 1'b1;
        tick();
        RESP_READY = 1'b0;
        FLUSH = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_total++; if (BUSY !== 1'b0 || SE !== 1'b0) $display("FAIL flush2_ignored[%0d]: got busy=%b se=%b want 0 0", k, BUSY, SE); else n_pass++;
        end
        FLUSH = 1'b0;
    endtask

    task automatic test_load_beats_flush();
        logic [N-1:0] pat;
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hF0;
        tick();
        LOAD_VALID = 1'b0;
        tick(N + 1);
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL prio_pre_rv: got %b want 0", RESP_VALID); else n_pass++;
        n_total++; if (chain !== 8'h0F) $display("FAIL prio_pre_chain: got %h want 0f", chain); else n_pass++;
        pat = 8'h99;
        FLUSH = 1'b1; LOAD_VALID = 1'b1; LOAD_DATA = pat;
        tick();
        FLUSH = 1'b0; LOAD_VALID = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_total++; if (SI !== pat[N-1-k]) $display("FAIL prio_si[%0d]: got %b want %b", k, SI, pat[N-1-k]); else n_pass++;
            tick();
        end
        n_total++; if (CAP_STROBE !== 1'b1) $display("FAIL prio_cap: got %b want 1", CAP_STROBE); else n_pass++;
        n_total++; if (RESP_VALID !== 1'b1) $display("FAIL prio_rv: got %b want 1", RESP_VALID); else n_pass++;
        n_total++; if (RESP_DATA !== 8'h0F) $display("FAIL prio_rd: got %h want 0f", RESP_DATA); else n_pass++;
        RESP_READY = 1'b1;
        tick();
        RESP_READY = 1'b0;
        n_total++; if (chain !== 8'h66) $display("FAIL prio_chain: got %h want 66", chain); else n_pass++;
    endtask

    task automatic test_abort();
        LOAD_VALID = 1'b1; LOAD_DATA = 8'h12;
        tick();
        LOAD_VALID = 1'b0;
        tick(3);
        n_total++; if (BUSY !== 1'b1 || SE !== 1'b1) $display("FAIL abort_pre: got busy=%b se=%b want 1 1", BUSY, SE); else n_pass++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_total++; if (SE !== 1'b0 || SI !== 1'b0) $display("FAIL abort_se_si: got se=%b si=%b want 0 0", SE, SI); else n_pass++;
        n_total++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b want 0", BUSY); else n_pass++;
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL abort_rv: got %b want 0", RESP_VALID); else n_pass++;
        n_total++; if (LOAD_READY !== 1'b1) $display("FAIL abort_lr: got %b want 1", LOAD_READY); else n_pass++;
        LOAD_VALID = 1'b1; LOAD_DATA = 8'hFF;
        tick();
        LOAD_VALID = 1'b0;
        tick(N);
        n_total++; if (CAP_STROBE !== 1'b1) $display("FAIL abort_ff_cap: got %b want 1", CAP_STROBE); else n_pass++;
        n_total++; if (RESP_VALID !== 1'b0) $display("FAIL abort_ff_rv: got %b want 0", RESP_VALID); else n_pass++;
        tick();
        n_total++; if (RESP_VALID !== 1'b0 || BUSY !== 1'b0) $display("FAIL abort_ff_idle: got rv=%b busy=%b want 0 0", RESP_VALID, BUSY); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        test_reset();
        test_first_load();
        test_second_load_backpressure();
        test_flush();
        test_load_beats_flush();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
